// File: rtl/data_ram_responder.sv
// data_ram_responder: memory-side end of the EXE-stage data RAM port.
// Word-organised array with byte write enables, read-first response with
// optional wait states, sticky out-of-range capture and debug access counters.
module data_ram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_ram_en,
  input  logic [3:0]  data_ram_w_en_4bit,
  input  logic [31:0] data_ram_addr,
  input  logic [31:0] data_ram_w_data,
  output logic        data_ram_ready,
  output logic [31:0] data_ram_r_data,
  output logic        data_ram_r_valid,
  output logic        data_ram_err,
  output logic [31:0] data_ram_err_addr,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH) << 2;
  // Only meaningful for WAIT_CYCLES >= 2; smaller settings never enter WAIT.
  localparam logic [2:0]  WAIT_LOAD   = 3'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state;
  logic [31:0] mem [DEPTH];
  logic [31:0] offset;
  logic        in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic        accept;
  logic        is_write;
  logic [31:0] snap_word;
  logic [31:0] hold_word;
  logic [2:0]  wait_cnt;

  // Decode relative to BASE_ADDR; the subtraction wraps so addresses below the
  // base land far above the window and are rejected by the single compare.
  assign offset         = data_ram_addr - BASE_ADDR;
  assign in_range       = {1'b0, offset} < RANGE_BYTES;
  assign word_idx       = offset[ADDR_WIDTH+1:2];
  assign data_ram_ready = (state == ST_IDLE) && reset;
  assign accept         = data_ram_en && data_ram_ready;
  assign is_write       = |data_ram_w_en_4bit;
  // Content before the accept edge: the write below lands at that same edge,
  // so sampling here gives read-first behaviour.
  assign snap_word      = in_range ? mem[word_idx] : 32'h0;

  // Byte-lane write into the array at the accept edge.
  // NOTE: the array is deliberately left out of reset so it maps onto RAM
  // macros; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (accept && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (data_ram_w_en_4bit[b]) begin
          mem[word_idx][8*b +: 8] <= data_ram_w_data[8*b +: 8];
        end
      end
    end
  end

  // Response FSM: immediate response, or hold word plus countdown then RESP.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, which is what makes the read-first snapshot work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      data_ram_r_data  <= 32'h0;
      data_ram_r_valid <= 1'b0;
      hold_word        <= 32'h0;
      wait_cnt         <= 3'd0;
    end else begin
      data_ram_r_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (WAIT_CYCLES == 0) begin
              data_ram_r_data  <= snap_word;
              data_ram_r_valid <= 1'b1;
            end else if (WAIT_CYCLES == 1) begin
              // A single busy cycle is the RESP cycle itself.
              data_ram_r_data  <= snap_word;
              data_ram_r_valid <= 1'b1;
              state            <= ST_RESP;
            end else begin
              hold_word <= snap_word;
              wait_cnt  <= WAIT_LOAD;
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Leave as the count reaches zero so RESP is the W-th busy cycle.
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            data_ram_r_data  <= hold_word;
            data_ram_r_valid <= 1'b1;
            state            <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky out-of-range capture (first error address wins) and saturating counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_ram_err      <= 1'b0;
      data_ram_err_addr <= 32'h0;
      rd_count          <= 16'h0;
      wr_count          <= 16'h0;
    end else if (accept) begin
      if (!in_range) begin
        data_ram_err <= 1'b1;
        if (!data_ram_err) begin
          data_ram_err_addr <= data_ram_addr;
        end
      end
      if (is_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule
